// File: rtl/genetico_pkg.sv
// Shared parameters, chromosome layout and FSM encoding for the genetico evaluation controller.
package genetico_pkg;

    localparam int unsigned N_LE      = 29;
    localparam int unsigned LE_CFG_W  = 15;
    localparam int unsigned N_OUT     = 8;
    localparam int unsigned OUT_SEL_W = 6;
    localparam int unsigned CHROM_W   = 8;
    localparam int unsigned CFG_BITS  = N_LE * LE_CFG_W + N_OUT * OUT_SEL_W;
    localparam int unsigned N_VEC     = 1 << CHROM_W;
    localparam int unsigned FIT_W     = 12;
    localparam int unsigned FIT_MAX   = N_VEC * CHROM_W;
    localparam int unsigned CNT_W     = $clog2(CFG_BITS);
    localparam int unsigned MATCH_W   = $clog2(CHROM_W + 1);

    // Chromosome as held in the shift register: LE configs above output selects.
    typedef struct packed {
        logic [N_LE-1:0][LE_CFG_W-1:0]   les;
        logic [N_OUT-1:0][OUT_SEL_W-1:0] outs;
    } chrom_cfg_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EVAL  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/genetico_eval_ctrl_match_count.sv
// Counts bit positions where the array output agrees with the target word.
module match_count
    import genetico_pkg::*;
(
    input  logic [CHROM_W-1:0] out_i,
    input  logic [CHROM_W-1:0] tgt_i,
    output logic [MATCH_W-1:0] match_c
);

    always_comb begin
        match_c = '0;
        for (int unsigned i = 0; i < CHROM_W; i++) begin
            match_c = match_c + MATCH_W'(~(out_i[i] ^ tgt_i[i]));
        end
    end

endmodule

// File: rtl/genetico_eval_ctrl.sv
// Serial chromosome loader and truth-table sweep/fitness controller for the genetico array.
// Optional GENETICO_ABORT_EN adds an abort input that cancels a running sweep.
module genetico_eval_ctrl
    import genetico_pkg::*;
(
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            cfg_valid,
    input  logic                            cfg_bit,
    output logic                            cfg_ready,
    output logic                            cfg_loaded,
    input  logic                            start,
`ifdef GENETICO_ABORT_EN
    input  logic                            abort,
`endif
    output logic                            busy,
    output logic                            done,
    output logic [FIT_W-1:0]                fitness,
    output logic                            perfect,
    output logic [N_LE-1:0][LE_CFG_W-1:0]   conf_les,
    output logic [N_OUT-1:0][OUT_SEL_W-1:0] conf_outs,
    output logic [CHROM_W-1:0]              chrom_in,
    input  logic [CHROM_W-1:0]              chrom_out,
    output logic [CHROM_W-1:0]              tgt_addr,
    input  logic [CHROM_W-1:0]              tgt_data
);

    state_e              state_q, state_d;
    logic [CFG_BITS-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                loaded_q, loaded_d;
    logic [CHROM_W-1:0]  vec_q, vec_d;
    logic [CHROM_W-1:0]  out_q, out_d;
    logic                vld_q, vld_d;
    logic [FIT_W-1:0]    acc_q, acc_d;
    logic [FIT_W-1:0]    fitness_q, fitness_d;
    logic                perfect_q, perfect_d;
    logic                ready_q, ready_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [MATCH_W-1:0]  match_c;
    logic                abort_c;
    chrom_cfg_t          cfg_view;

`ifdef GENETICO_ABORT_EN
    assign abort_c = abort;
`else
    assign abort_c = 1'b0;
`endif

    // Compares the output registered last cycle with the ROM word for the same vector.
    match_count u_match_count (
        .out_i   (out_q),
        .tgt_i   (tgt_data),
        .match_c (match_c)
    );

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        cnt_d     = cnt_q;
        loaded_d  = loaded_q;
        vec_d     = vec_q;
        out_d     = out_q;
        vld_d     = 1'b0;
        acc_d     = acc_q;
        fitness_d = fitness_q;
        perfect_d = perfect_q;

        case (state_q)
            ST_IDLE: begin
                // A config bit in the same cycle as start wins; start is retried by the host.
                if (cfg_valid) begin
                    shreg_d = {shreg_q[CFG_BITS-2:0], cfg_bit};
                    if (cnt_q == CNT_W'(CFG_BITS - 1)) begin
                        cnt_d    = '0;
                        loaded_d = 1'b1;
                    end else begin
                        if (cnt_q == '0) begin
                            loaded_d = 1'b0;
                        end
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else if (start && loaded_q) begin
                    acc_d   = '0;
                    vec_d   = '0;
                    state_d = ST_EVAL;
                end
            end
            ST_EVAL: begin
                vec_d = vec_q + CHROM_W'(1);
                out_d = chrom_out;
                vld_d = 1'b1;
                if (vld_q) begin
                    acc_d = acc_q + FIT_W'(match_c);
                end
                if (abort_c) begin
                    vec_d   = '0;
                    state_d = ST_IDLE;
                end else if (vec_q == '1) begin
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (abort_c) begin
                    state_d = ST_IDLE;
                end else begin
                    fitness_d = acc_q + FIT_W'(match_c);
                    perfect_d = (fitness_d == FIT_W'(FIT_MAX));
                    state_d   = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        ready_d = (state_d == ST_IDLE);
        busy_d  = (state_d == ST_EVAL) || (state_d == ST_FLUSH);
        done_d  = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            shreg_q   <= '0;
            cnt_q     <= '0;
            loaded_q  <= 1'b0;
            vec_q     <= '0;
            out_q     <= '0;
            vld_q     <= 1'b0;
            acc_q     <= '0;
            fitness_q <= '0;
            perfect_q <= 1'b0;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            cnt_q     <= cnt_d;
            loaded_q  <= loaded_d;
            vec_q     <= vec_d;
            out_q     <= out_d;
            vld_q     <= vld_d;
            acc_q     <= acc_d;
            fitness_q <= fitness_d;
            perfect_q <= perfect_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign cfg_view   = shreg_q;
    assign conf_les   = cfg_view.les;
    assign conf_outs  = cfg_view.outs;
    assign cfg_ready  = ready_q;
    assign cfg_loaded = loaded_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign fitness    = fitness_q;
    assign perfect    = perfect_q;
    assign chrom_in   = vec_q;
    assign tgt_addr   = vec_q;

endmodule

// File: tb/tb_genetico_eval_ctrl.sv
// Self-checking bench: timeline model of the controller plus a toy array and target ROM.
module tb_genetico_eval_ctrl;

    localparam int CFG = 483;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              cfg_valid, cfg_bit, start, abort;
    logic              cfg_ready, cfg_loaded, busy, done, perfect;
    logic [11:0]       fitness;
    logic [28:0][14:0] conf_les;
    logic [7:0][5:0]   conf_outs;
    logic [7:0]        chrom_in, chrom_out, tgt_addr, tgt_data;
    int                rom_mode;

    int n_checks = 0;
    int n_pass   = 0;

    genetico_eval_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_valid  (cfg_valid),
        .cfg_bit    (cfg_bit),
        .cfg_ready  (cfg_ready),
        .cfg_loaded (cfg_loaded),
        .start      (start),
`ifdef GENETICO_ABORT_EN
        .abort      (abort),
`endif
        .busy       (busy),
        .done       (done),
        .fitness    (fitness),
        .perfect    (perfect),
        .conf_les   (conf_les),
        .conf_outs  (conf_outs),
        .chrom_in   (chrom_in),
        .chrom_out  (chrom_out),
        .tgt_addr   (tgt_addr),
        .tgt_data   (tgt_data)
    );

    always #5 clk = ~clk;

    // Toy array: output i copies input bit conf_outs[i] when that select is below 8.
    function automatic logic [7:0] arr_out(input logic [7:0] a, input logic [47:0] outs);
        logic [7:0] o;
        logic [5:0] sel;
        o = '0;
        for (int i = 0; i < 8; i++) begin
            sel = outs[6*i +: 6];
            if (sel < 6'd8) o[i] = a[sel[2:0]];
        end
        return o;
    endfunction

    function automatic logic [7:0] rom_f(input logic [7:0] a, input int mode);
        case (mode)
            1:       return ~a;
            2:       return a ^ 8'h01;
            default: return a;
        endcase
    endfunction

    assign chrom_out = arr_out(chrom_in, conf_outs);
    always @(posedge clk) tgt_data <= rom_f(tgt_addr, rom_mode);

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h required %0h", nm, act, exp);
    endtask

    task automatic chk_cfg(input string nm, input logic [482:0] act, input logic [482:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h required %0h", nm, act, exp);
    endtask

    // ---------------- behavioural model ----------------
    bit          m_bits[$];
    int          m_t      = 0;   // cycles since accepted start, 0 = idle
    int          m_cnt    = 0;
    bit          m_loaded = 1'b0;
    bit          m_perf   = 1'b0;
    logic [11:0] m_fit    = '0;
    logic [11:0] m_pend   = '0;

    function automatic logic [482:0] model_vec();
        logic [482:0] v;
        int sz;
        v  = '0;
        sz = m_bits.size();
        for (int j = 0; j < sz; j++) v[sz-1-j] = m_bits[j];
        return v;
    endfunction

    function automatic logic [11:0] model_fitness(input logic [482:0] v, input int mode);
        int sum;
        logic [7:0] av, o, r;
        sum = 0;
        for (int a = 0; a < 256; a++) begin
            av = 8'(a);
            o  = arr_out(av, v[47:0]);
            r  = rom_f(av, mode);
            for (int b = 0; b < 8; b++) if (o[b] == r[b]) sum++;
        end
        return 12'(sum);
    endfunction

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_t = 0; m_bits.delete(); m_cnt = 0; m_loaded = 1'b0;
                m_fit = '0; m_perf = 1'b0;
            end else if (m_t == 0) begin
                if (cfg_valid) begin
                    m_bits.push_back(cfg_bit);
                    if (m_bits.size() > CFG) void'(m_bits.pop_front());
                    if (m_cnt == 0) m_loaded = 1'b0;
                    m_cnt++;
                    if (m_cnt == CFG) begin m_cnt = 0; m_loaded = 1'b1; end
                end else if (start && m_loaded) begin
                    m_t    = 1;
                    m_pend = model_fitness(model_vec(), rom_mode);
                end
            end else if (abort && m_t <= 257) begin
                m_t = 0;
            end else if (m_t == 258) begin
                m_t = 0;
            end else begin
                m_t++;
                if (m_t == 258) begin
                    m_fit  = m_pend;
                    m_perf = (m_pend == 12'd2048);
                end
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        chk("busy", 64'(busy), 64'(m_t >= 1 && m_t <= 257));
        chk("done", 64'(done), 64'(m_t == 258));
        chk("cfg_ready", 64'(cfg_ready), 64'(m_t == 0));
        chk("cfg_loaded", 64'(cfg_loaded), 64'(m_loaded));
        chk("fitness", 64'(fitness), 64'(m_fit));
        chk("perfect", 64'(perfect), 64'(m_perf));
        chk_cfg("conf", {conf_les, conf_outs}, model_vec());
        if (m_t >= 1 && m_t <= 256) begin
            chk("chrom_in", 64'(chrom_in), 64'(m_t - 1));
            chk("tgt_addr", 64'(tgt_addr), 64'(m_t - 1));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic send_range(input logic [482:0] v, input int hi, input int lo, input bit gap);
        for (int i = hi; i >= lo; i--) begin
            cfg_valid = 1'b1;
            cfg_bit   = v[i];
            cycle();
            if (gap && (i % 3 == 0)) begin
                cfg_valid = 1'b0;
                cycle();
            end
        end
        cfg_valid = 1'b0;
    endtask

    task automatic run_eval(input int mode, input logic [11:0] exp_fit, input logic exp_perf,
                            input bit hold_cfg, input string tag);
        int n, nbusy;
        bit seen;
        rom_mode = mode;
        start = 1'b1;
        cycle();
        start = 1'b0;
        if (hold_cfg) begin cfg_valid = 1'b1; cfg_bit = 1'b1; end
        n = 1; nbusy = 0; seen = 1'b0;
        while (n < 300) begin
            if (done) begin seen = 1'b1; break; end
            if (busy) nbusy++;
            cycle();
            n++;
        end
        cfg_valid = 1'b0;
        chk({tag, " done_seen"}, 64'(seen), 64'(1));
        chk({tag, " done_cycle"}, 64'(n), 64'(258));
        chk({tag, " busy_cycles"}, 64'(nbusy), 64'(257));
        chk({tag, " fitness"}, 64'(fitness), 64'(exp_fit));
        chk({tag, " perfect"}, 64'(perfect), 64'(exp_perf));
        cycle();
    endtask

    logic [482:0] one_vec, id_vec, zero_vec;

    initial begin
        int ndone;
        rst_n = 1'b0; cfg_valid = 1'b0; cfg_bit = 1'b0; start = 1'b0; abort = 1'b0;
        rom_mode = 0;
        one_vec = '0; one_vec[482] = 1'b1;
        zero_vec = '0;
        id_vec = '0;
        for (int i = 0; i < 8; i++) id_vec[6*i +: 6] = 6'(i);

        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        chk("rst cfg_ready", 64'(cfg_ready), 64'(1));
        chk("rst busy", 64'(busy), 64'(0));
        chk("rst fitness", 64'(fitness), 64'(0));
        chk("rst chrom_in", 64'(chrom_in), 64'(0));
        start = 1'b1; cycle(); start = 1'b0; cycle();
        chk("start_unloaded busy", 64'(busy), 64'(0));

        // Single leading 1 with gapped valid.
        send_range(one_vec, 482, 1, 1'b1);
        chk("first_bit loaded_early", 64'(cfg_loaded), 64'(0));
        send_range(one_vec, 0, 0, 1'b1);
        chk("first_bit loaded", 64'(cfg_loaded), 64'(1));
        chk("first_bit le28_14", 64'(conf_les[28][14]), 64'(1));
        chk_cfg("first_bit all", {conf_les, conf_outs}, one_vec);

        // Identity config against several ROMs, back to back.
        send_range(id_vec, 482, 0, 1'b0);
        run_eval(0, 12'd2048, 1'b1, 1'b0, "ident");
        run_eval(2, 12'd1792, 1'b0, 1'b0, "lsb_flip");
        run_eval(1, 12'd0, 1'b0, 1'b0, "inverted");
        run_eval(0, 12'd2048, 1'b1, 1'b1, "hold_cfg");
        chk_cfg("hold_cfg conf", {conf_les, conf_outs}, id_vec);

`ifdef GENETICO_ABORT_EN
        rom_mode = 1;
        start = 1'b1; cycle(); start = 1'b0;
        repeat (100) cycle();
        chk("abort k", 64'(chrom_in), 64'(100));
        abort = 1'b1; cycle(); abort = 1'b0;
        chk("abort busy", 64'(busy), 64'(0));
        chk("abort ready", 64'(cfg_ready), 64'(1));
        ndone = 0;
        for (int i = 0; i < 300; i++) begin
            if (done) ndone++;
            cycle();
        end
        chk("abort no_done", 64'(ndone), 64'(0));
        chk("abort fitness", 64'(fitness), 64'(2048));
        chk("abort loaded", 64'(cfg_loaded), 64'(1));
`else
        ndone = 0;
`endif

        // Partial reload: 100 bits, then start must be ignored.
        send_range(id_vec, 482, 383, 1'b0);
        chk("partial loaded", 64'(cfg_loaded), 64'(0));
        start = 1'b1; cycle(); start = 1'b0; cycle();
        chk("partial start busy", 64'(busy), 64'(0));
        send_range(id_vec, 382, 0, 1'b0);
        chk("reload loaded", 64'(cfg_loaded), 64'(1));
        run_eval(2, 12'd1792, 1'b0, 1'b0, "reload");

        // Reset in the middle of a sweep.
        rom_mode = 0;
        start = 1'b1; cycle(); start = 1'b0;
        repeat (50) cycle();
        chk("midrst k", 64'(chrom_in), 64'(50));
        rst_n = 1'b0;
        cycle(); cycle();
        chk("midrst busy", 64'(busy), 64'(0));
        chk("midrst loaded", 64'(cfg_loaded), 64'(0));
        chk("midrst fitness", 64'(fitness), 64'(0));
        chk_cfg("midrst conf", {conf_les, conf_outs}, zero_vec);
        rst_n = 1'b1;
        cycle();
        start = 1'b1; cycle(); start = 1'b0; cycle();
        chk("midrst start busy", 64'(busy), 64'(0));

        repeat (2) cycle();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
